// File: rtl/cpu15_pkg.sv
// -----------------------------------------------------------------------------
// cpu15_pkg
// Definitions shared by the cpu15 peripherals: the UART frame-state
// enumeration and the 8N1 framing constants.
// -----------------------------------------------------------------------------
package cpu15_pkg;

    // Byte transmitter sequencing: idle line, start bit, data bits, stop bit.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Sends one 8N1 byte: a start bit, eight data bits LSB first and a stop bit,
// each held for BAUD_DIV clock cycles.
//
// Ports
//   CLK      system clock
//   RESET_N  asynchronous active-low reset
//   START    request strobe; taken while idle or on the last stop-bit cycle
//   DATA     byte to send, captured together with START
//   TXD      registered serial output, idle high
//   DONE     high for the single final cycle of the stop bit
// -----------------------------------------------------------------------------
module uart_byte_tx
    import cpu15_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [7:0] DATA,
    output logic       TXD,
    output logic       DONE
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        txd_q, txd_d;
    logic        bit_end;

    assign bit_end = (baud_cnt_q == BAUD_LAST);

    // A request accepted on the last stop cycle goes straight to the next start
    // bit, so back-to-back bytes leave no idle gap on the line.
    assign DONE = (state_q == ST_STOP) && bit_end;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        txd_d      = UART_STOP_BIT;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (START) begin
                    state_d = ST_START;
                    data_d  = DATA;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d    = ST_DATA;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (START) begin
                        state_d = ST_START;
                        data_d  = DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
            end
        endcase

        // TXD is decoded from the next state so the pin changes exactly on
        // the bit-boundary edge and stays glitch-free.
        case (state_d)
            ST_START: txd_d = UART_START_BIT;
            ST_DATA:  txd_d = data_d[bit_idx_d];
            default:  txd_d = UART_STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            txd_q      <= UART_STOP_BIT;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // the pre-edge value of every other register.
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
        end
    end

    assign TXD = txd_q;

endmodule

// File: rtl/io64_uart_tx.sv
// -----------------------------------------------------------------------------
// io64_uart_tx
// Watches the cpu15 IO64 output word and, whenever it changes, sends it on an
// 8N1 UART line as two bytes, high byte first. One pending word absorbs a
// change that arrives mid-transmission; overwritten pending words are counted.
//
// Ports
//   CLK        system clock
//   RESET_N    asynchronous active-low reset
//   IO64_DATA  the core's IO64_OUT word, sampled directly (same clock domain)
//   TXD        registered UART output, idle high
//   BUSY       registered, high while a two-byte frame pair is on the line
//   OVR_CNT    registered count of overwritten pending words, saturating
// -----------------------------------------------------------------------------
module io64_uart_tx
    import cpu15_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] IO64_DATA,
    output logic        TXD,
    output logic        BUSY,
    output logic [7:0]  OVR_CNT
);

    logic [15:0] prev_q;
    logic        chg_q;
    logic [15:0] word_q, word_d;
    logic        byte_sel_q, byte_sel_d;
    logic        busy_q, busy_d;
    logic        pend_valid_q, pend_valid_d;
    logic [15:0] pend_data_q, pend_data_d;
    logic [7:0]  ovr_cnt_q, ovr_cnt_d;

    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        launch;
    logic [15:0] launch_word;
    logic        chg_to_pend;

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (tx_start),
        .DATA    (tx_byte),
        .TXD     (TXD),
        .DONE    (tx_done)
    );

    // Change detection is registered: a change sampled on one edge acts on the
    // next, which keeps IO64_DATA off every combinational path to the outputs
    // and gives the same one-edge latency for idle and back-to-back launches.
    always_comb begin
        word_d       = word_q;
        byte_sel_d   = byte_sel_q;
        busy_d       = busy_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        ovr_cnt_d    = ovr_cnt_q;
        tx_start     = 1'b0;
        tx_byte      = word_q[7:0];
        launch       = 1'b0;
        launch_word  = prev_q;
        chg_to_pend  = chg_q;

        if (!busy_q) begin
            if (chg_q) begin
                launch      = 1'b1;
                chg_to_pend = 1'b0;
            end
        end else if (tx_done) begin
            if (!byte_sel_q) begin
                // Low byte follows the high byte's stop bit with no gap.
                tx_start   = 1'b1;
                byte_sel_d = 1'b1;
            end else if (pend_valid_q) begin
                // The older pending word goes first; a simultaneous change
                // refills the slot below.
                launch       = 1'b1;
                launch_word  = pend_data_q;
                pend_valid_d = 1'b0;
            end else if (chg_q) begin
                launch      = 1'b1;
                chg_to_pend = 1'b0;
            end else begin
                busy_d = 1'b0;
            end
        end

        if (launch) begin
            tx_start   = 1'b1;
            tx_byte    = launch_word[15:8];
            word_d     = launch_word;
            byte_sel_d = 1'b0;
            busy_d     = 1'b1;
        end

        // Only reachable while busy: a word arriving after the slot has been
        // drained this cycle is not an overwrite.
        if (chg_to_pend) begin
            if (pend_valid_d && (ovr_cnt_q != 8'hFF)) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
            pend_data_d  = prev_q;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_q       <= '0;
            chg_q        <= 1'b0;
            word_q       <= '0;
            byte_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            // NOTE: data registers guarded by a valid flag are still reset;
            // the cost is trivial and it keeps post-reset state fully defined.
            pend_data_q  <= '0;
            ovr_cnt_q    <= '0;
        end else begin
            prev_q       <= IO64_DATA;
            chg_q        <= (IO64_DATA != prev_q);
            word_q       <= word_d;
            byte_sel_q   <= byte_sel_d;
            busy_q       <= busy_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            ovr_cnt_q    <= ovr_cnt_d;
        end
    end

    assign BUSY    = busy_q;
    assign OVR_CNT = ovr_cnt_q;

endmodule

// File: tb/tb_io64_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_io64_uart_tx
// Directed bench for io64_uart_tx with BAUD_DIV=4. Inputs change on the
// falling clock edge and outputs are sampled on the falling edge, half a
// cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_io64_uart_tx;

    localparam int unsigned BAUD  = 4;
    localparam int          FRAME = 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] io64_data = 16'h0000;
    logic        txd;
    logic        busy;
    logic [7:0]  ovr_cnt;

    int vectors = 0;
    int miscompares = 0;

    io64_uart_tx #(
        .BAUD_DIV (BAUD)
    ) dut (
        .CLK       (clk),
        .RESET_N   (rst_n),
        .IO64_DATA (io64_data),
        .TXD       (txd),
        .BUSY      (busy),
        .OVR_CNT   (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected TXD waveform of one 8N1 byte, one bit per clock cycle,
    // cycle 0 in bit 0: start 0, data LSB first, stop 1, each BAUD cycles.
    function automatic logic [63:0] frame_wave(input logic [7:0] b);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < FRAME; k++) begin
            int idx;
            idx = k / int'(BAUD);
            if (idx == 0)      w[k] = 1'b0;
            else if (idx == 9) w[k] = 1'b1;
            else               w[k] = b[idx-1];
        end
        return w;
    endfunction

    // Wait (bounded) for the start bit; called on a falling edge.
    task automatic wait_start(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (txd !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 64'(txd), 64'd0);
    endtask

    // Wait (bounded) for BUSY to drop; called on a falling edge.
    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_seen"}, 64'(busy), 64'd0);
    endtask

    // Records 2*FRAME cycles starting at the falling edge on which the start
    // bit is first visible, optionally changing IO64 after chosen samples, and
    // returns positioned on the first cycle after the pair.
    task automatic capture_pair(input string tag, input logic [15:0] word,
                                input int c0_idx, input logic [15:0] c0_val,
                                input int c1_idx, input logic [15:0] c1_val);
        logic [63:0] hi_w;
        logic [63:0] lo_w;
        int          busy_cycles;
        hi_w = '0;
        lo_w = '0;
        busy_cycles = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k < FRAME) hi_w[k] = txd;
            else           lo_w[k-FRAME] = txd;
            if (busy === 1'b1) busy_cycles++;
            if (k == c0_idx) io64_data = c0_val;
            if (k == c1_idx) io64_data = c1_val;
            @(negedge clk);
        end
        check({tag, "_hi_byte"}, hi_w, frame_wave(word[15:8]));
        check({tag, "_lo_byte"}, lo_w, frame_wave(word[7:0]));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd80);
    endtask

    initial begin
        int bad;

        // Reset hold with an all-zero word: the line stays quiet.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", 64'(txd), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovr", 64'(ovr_cnt), 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || ovr_cnt !== 8'd0) bad++;
        end
        check("zero_word_ignored", 64'(bad), 64'd0);

        // First word: sampled on the next rising edge, start bit one edge later.
        io64_data = 16'h12A5;
        @(negedge clk);
        check("t1_pre_start_txd", 64'(txd), 64'd1);
        check("t1_pre_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("t1_start_txd", 64'(txd), 64'd0);
        check("t1_start_busy", 64'(busy), 64'd1);
        capture_pair("t1", 16'h12A5, -1, 16'h0, -1, 16'h0);
        check("t1_end_busy", 64'(busy), 64'd0);
        check("t1_end_txd", 64'(txd), 64'd1);

        // Pending launch: second word follows with no gap, 160 busy cycles.
        io64_data = 16'h0001;
        wait_start("t2", 8);
        capture_pair("t2a", 16'h0001, 10, 16'h0002, -1, 16'h0);
        check("t2_gapless_txd", 64'(txd), 64'd0);
        check("t2_gapless_busy", 64'(busy), 64'd1);
        capture_pair("t2b", 16'h0002, -1, 16'h0, -1, 16'h0);
        check("t2_end_busy", 64'(busy), 64'd0);
        check("t2_ovr", 64'(ovr_cnt), 64'd0);

        // Overwrite: 0x2222 is replaced by 0x3333 before it can be sent.
        io64_data = 16'h1111;
        wait_start("t3", 8);
        capture_pair("t3a", 16'h1111, 10, 16'h2222, 20, 16'h3333);
        check("t3_gapless_txd", 64'(txd), 64'd0);
        capture_pair("t3b", 16'h3333, -1, 16'h0, -1, 16'h0);
        check("t3_end_busy", 64'(busy), 64'd0);
        check("t3_ovr", 64'(ovr_cnt), 64'd1);

        // Saturation: a new word every cycle for 300 cycles overwrites far
        // more than 255 pending words.
        for (int i = 0; i < 300; i++) begin
            io64_data = 16'h4000 + 16'(i);
            @(negedge clk);
        end
        wait_idle("t4", 400);
        check("t4_ovr_saturated", 64'(ovr_cnt), 64'd255);

        // Boundary: the new word is sampled on the edge opening the final
        // stop-bit cycle and starts on the very next cycle.
        io64_data = 16'h3C81;
        wait_start("t5", 8);
        capture_pair("t5a", 16'h3C81, 2 * FRAME - 2, 16'hC3E7, -1, 16'h0);
        check("t5_next_txd", 64'(txd), 64'd0);
        check("t5_next_busy", 64'(busy), 64'd1);
        capture_pair("t5b", 16'hC3E7, -1, 16'h0, -1, 16'h0);
        check("t5_end_busy", 64'(busy), 64'd0);

        // Mid-frame reset during the high byte's data bits.
        io64_data = 16'hBEEF;
        wait_start("t6", 8);
        repeat (12) @(negedge clk);
        check("t6_mid_data_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_txd", 64'(txd), 64'd1);
        check("t6_async_busy", 64'(busy), 64'd0);
        check("t6_async_ovr", 64'(ovr_cnt), 64'd0);
        io64_data = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t6_no_resume", 64'(bad), 64'd0);
        io64_data = 16'h8001;
        wait_start("t6b", 8);
        capture_pair("t6b", 16'h8001, -1, 16'h0, -1, 16'h0);
        check("t6b_end_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
